// File: rtl/sub_bytes_serial.sv
// -----------------------------------------------------------------------------
// sub_bytes_serial
//   Forward AES SubBytes engine. A 128-bit state is accepted through a
//   valid/ready handshake. LANES bytes are pushed through the S-box on each
//   clock until all 16 bytes are done. The result is then held until the
//   downstream stage takes it.
//
//   Parameters
//     LANES      bytes substituted per cycle (1, 2, 4, 8 or 16)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   data_in holds a state to substitute
//     in_ready   engine is idle and can accept a state
//     data_in    input state, byte k = data_in[8k+7:8k]
//     out_valid  data_out holds a completed result
//     out_ready  downstream accepts data_out
//     data_out   work register (partial values during RUN)
//     busy       transaction in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module sub_bytes_serial #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int N     = 16 / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Forward AES S-box. Entry 0 sits in the most significant byte, so
  // SBOX[x] returns S(x) directly.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [127:0]       work_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               busy_reg;

  logic [7:0] sub_in  [LANES];
  logic [7:0] sub_out [LANES];

  // One S-box per lane. Lane gi handles byte cnt*LANES+gi of the work register.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign sub_in[gi]  = work_reg[(int'(cnt_reg) * LANES + gi) * 8 +: 8];
      assign sub_out[gi] = SBOX[sub_in[gi]];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // in_ready only rises on the first edge after reset, so a state
          // offered during that edge is not accepted.
          in_ready_reg <= 1'b1;
          if (in_valid && in_ready_reg) begin
            work_reg     <= data_in;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < LANES; i++) begin
            work_reg[(int'(cnt_reg) * LANES + i) * 8 +: 8] <= sub_out[i];
          end
          if (cnt_reg == CNT_W'(N - 1)) begin
            cnt_reg       <= '0;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign data_out  = work_reg;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_serial
//   Self-checking bench for sub_bytes_serial. The main instance uses LANES=4.
//   Four more instances (LANES 1, 2, 8, 16) share one stimulus for the
//   latency comparison. The golden S-box is computed from the GF(2^8)
//   inverse and the affine map, not taken from a table.
// -----------------------------------------------------------------------------
module tb_sub_bytes_serial;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  localparam int NX = 4;
  localparam int X_LANES [NX] = '{1, 2, 8, 16};

  logic         x_in_valid;
  logic [127:0] x_data_in;
  logic         x_out_ready;
  logic         x_in_ready  [NX];
  logic         x_out_valid [NX];
  logic [127:0] x_data_out  [NX];
  logic         x_busy      [NX];

  int n_checks = 0;
  int n_errors = 0;

  sub_bytes_serial #(.LANES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  generate
    for (genvar gi = 0; gi < NX; gi++) begin : g_x
      sub_bytes_serial #(.LANES(X_LANES[gi])) u_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (x_in_valid),
        .in_ready  (x_in_ready[gi]),
        .data_in   (x_data_in),
        .out_valid (x_out_valid[gi]),
        .out_ready (x_out_ready),
        .data_out  (x_data_out[gi]),
        .busy      (x_busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- golden model ----------------
  logic [7:0] golden [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int i = 1; i < 256; i++) begin
        if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One transaction on the main instance. Returns the result and the number of
  // edges from accept to out_valid. The task then completes the output handshake.
  task automatic run_txn(input logic [127:0] din, output logic [127:0] dout, output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b1;
    data_in  = din;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};  // must not affect result
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    dout = data_out;
    chk("busy_in_done", 128'(busy), 128'(1));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", 128'(out_valid), 128'(0));
    chk("in_ready_after_hs", 128'(in_ready), 128'(1));
  endtask

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [8];
    logic [127:0] res;
    logic [127:0] held;
    logic [127:0] exp;
    logic [127:0] din;
    int           lat;
    int           x_lat [NX];
    logic [7:0]   perm [256];
    logic         seen_valid;

    vecs[0] = '{"zero",     128'h0, {16{8'h63}}};
    vecs[1] = '{"fips_r1",  128'h193de3bea0f4e22b9ac68d2ae9f84808,
                            128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[2] = '{"byte_53",  128'h53, {{15{8'h63}}, 8'hed}};
    vecs[3] = '{"byte_ff",  128'hff, {{15{8'h63}}, 8'h16}};
    vecs[4] = '{"byte_01",  128'h01, {{15{8'h63}}, 8'h7c}};
    vecs[5] = '{"byte_63",  128'h63, {{15{8'h63}}, 8'hfb}};
    vecs[6] = '{"all_ff",   {16{8'hff}}, {16{8'h16}}};
    vecs[7] = '{"ramp",     128'h0f0e0d0c0b0a09080706050403020100,
                            128'h76abd7fe2b670130c56f6bf27b777c63};

    for (int i = 0; i < 256; i++) golden[i] = sbox_model(8'(i));

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    data_in     = '0;
    out_ready   = 1'b0;
    x_in_valid  = 1'b0;
    x_data_in   = '0;
    x_out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_data_out", data_out, 128'h0);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("in_ready_after_edge", 128'(in_ready), 128'(1));

    // Table of directed vectors on LANES=4.
    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].din, res, lat);
      chk({vecs[v].name, "_data"}, res, vecs[v].dout);
      chk({vecs[v].name, "_lat"}, 128'(lat), 128'(4));
    end

    // Latency and result for the other lane counts.
    @(negedge clk);
    x_in_valid = 1'b1;
    x_data_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    @(posedge clk);
    @(negedge clk);
    x_in_valid = 1'b0;
    x_data_in  = '0;
    for (int g = 0; g < NX; g++) x_lat[g] = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NX; g++) begin
        if (x_out_valid[g] && x_lat[g] == 0) x_lat[g] = k;
      end
    end
    for (int g = 0; g < NX; g++) begin
      chk($sformatf("lanes%0d_lat", X_LANES[g]), 128'(x_lat[g]), 128'(16 / X_LANES[g]));
      chk($sformatf("lanes%0d_data", X_LANES[g]), x_data_out[g],
          128'hd42711aee0bf98f1b8b45de51e415230);
    end
    x_out_ready = 1'b1;
    @(negedge clk);
    x_out_ready = 1'b0;

    // Backpressure in DONE with in_valid/data_in toggling.
    in_valid = 1'b1;
    data_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    held = data_out;
    chk("bp_first_result", held, 128'hd42711aee0bf98f1b8b45de51e415230);
    for (int k = 0; k < 10; k++) begin
      in_valid = ~in_valid;
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", k), 128'(out_valid), 128'(1));
      chk($sformatf("bp_data_%0d", k), data_out, held);
      chk($sformatf("bp_in_ready_%0d", k), 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", 128'(out_valid), 128'(0));
    chk("bp_data_kept", data_out, held);

    // Shuffled sweep of all 256 byte values, 16 per state.
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j = int'($urandom_range(0, i));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < 16; k++) begin
        din[k*8 +: 8] = perm[t*16 + k];
        exp[k*8 +: 8] = golden[perm[t*16 + k]];
      end
      run_txn(din, res, lat);
      chk($sformatf("sweep_%0d", t), res, exp);
    end

    // Reset pulse two edges into RUN.
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", 128'(out_valid), 128'(0));
    chk("midrun_rst_busy", 128'(busy), 128'(0));
    chk("midrun_rst_data", data_out, 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("no_result_after_rst", 128'(seen_valid), 128'(0));
    run_txn(128'h01, res, lat);
    chk("post_rst_data", res, {{15{8'h63}}, 8'h7c});
    chk("post_rst_lat", 128'(lat), 128'(4));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
